vec_lane_alu: RTL and testbench
===============================

# vec_lane_alu

Element-serial vector ALU sitting directly downstream of the processor's two-output operand selector. It takes the selected operand pair (y1 as A, y2 as B), each a packed vector of WIDTH/ELEM_W unsigned elements. It processes one element per cycle under a small FSM and returns the packed result with a zero flag over a valid/ready handshake to the writeback stage.

## Interface
- WIDTH, 24: packed operand/result width; must be a multiple of ELEM_W.
- ELEM_W, 8: element width; LANES = WIDTH/ELEM_W (3 at defaults).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair and op present.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  3  operation code, latched at accept.
- a  in  WIDTH  operand A (from selector y1).
- b  in  WIDTH  operand B (from selector y2).
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  packed result.
- zero  out  1  result == 0.

## Operation
- Element i occupies bits [ELEM_W*i+ELEM_W-1 : ELEM_W*i]; processing order i = 0 .. LANES-1.
- Ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL (shift A by B[2:0]), 110 SRL (same), 111 PASSA. All unsigned; ADD/SUB wrap mod 2^ELEM_W (see Configuration).
- FSM states IDLE, EXEC, DONE:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch a, b, op; clear result register; idx<=0; go EXEC.
  - EXEC: each cycle write element idx of result register from element idx of latched A/B; idx<=idx+1; after writing idx==LANES-1 go DONE.
  - DONE: out_valid=1; result/zero held stable. On out_valid&&out_ready go IDLE.
- No overlap: a new op is not accepted before the previous result handshake completes. in_valid is ignored outside IDLE.
- a/b/op may change after accept without effect.
- zero computed from the complete result register; meaningful only while out_valid=1.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, idx=0. Latched operands cleared to 0.
- Latency: accept at edge T; elements written at edges T+1..T+LANES; out_valid high from after edge T+LANES (T+3 at defaults).
- Throughput with out_ready tied high: one op per LANES+2 cycles (accept, LANES exec, DONE handshake cycle, then back in IDLE).
- Backpressure: out_ready low holds DONE indefinitely; result and zero must not change.
- rst asserted in any state (including mid-EXEC) forces reset values at the next edge; the partial result is discarded and no out_valid pulse occurs.
- idx width = clog2(LANES), minimum 1; idx never exceeds LANES-1.

## Configuration
- VEC_ALU_SAT_EN defined: ADD saturates each element to 2^ELEM_W-1 on carry out; SUB clamps to 0 on borrow. Other ops unchanged.
- Undefined: ADD/SUB wrap modulo 2^ELEM_W.

## Structure
- Shared package vec_pkg: ELEM_W default, alu_op_t enum (the eight codes above), alu_state_t enum (IDLE, EXEC, DONE).
- One combinational sub-module vec_elem_op: inputs op, ELEM_W-bit a/b elements; output ELEM_W-bit element result. It contains the VEC_ALU_SAT_EN conditional. The top holds FSM, idx counter, operand/result registers.

## Test plan
- Reset: hold rst 2 cycles -> in_ready=1, out_valid=0, result=0x000000, zero=1. Assert rst mid-EXEC -> next cycle IDLE, out_valid never pulses.
- ADD a=0x0102FF b=0x010101 -> out_valid after 3 edges, result=0x020300, zero=0 (wrap); with VEC_ALU_SAT_EN result=0x0203FF.
- SUB a=0x000010 b=0x000020 -> result=0x0000F0; with VEC_ALU_SAT_EN result=0x000000, zero=1.
- SLL a=0x018040 b=0x000002 -> result=0x040000. PASSA a=0xABCDEF -> result=0xABCDEF.
- Backpressure: out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, new in_valid ignored. Release out_ready -> IDLE next edge.
- Back-to-back: in_valid and out_ready held high, ops XOR 0xFF00FF^0x0F0F0F then AND -> accepts exactly 5 cycles apart; first result=0xF00FF0.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types for the element-serial vector ALU: op codes, FSM states, default element width.
package vec_pkg;

  localparam int unsigned ELEM_W_DEF = 8;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_SLL   = 3'b101,
    OP_SRL   = 3'b110,
    OP_PASSA = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/vec_elem_op.sv
// Single-element combinational ALU slice.
// VEC_ALU_SAT_EN: ADD saturates to all-ones on carry, SUB clamps to zero on borrow.
module vec_elem_op
  import vec_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] y
);

  logic [ELEM_W-1:0] add_res;
  logic [ELEM_W-1:0] sub_res;
  logic [2:0]        shamt;

  assign shamt = b[2:0];

`ifdef VEC_ALU_SAT_EN
  logic [ELEM_W:0] sum_ext;
  logic [ELEM_W:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  // Top bit of the extended result is carry out (ADD) or borrow (SUB).
  assign add_res  = sum_ext[ELEM_W] ? '1 : sum_ext[ELEM_W-1:0];
  assign sub_res  = diff_ext[ELEM_W] ? '0 : diff_ext[ELEM_W-1:0];
`else
  assign add_res = a + b;
  assign sub_res = a - b;
`endif

  always_comb begin
    y = '0;
    unique case (alu_op_t'(op))
      OP_ADD:   y = add_res;
      OP_SUB:   y = sub_res;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_SLL:   y = a << shamt;
      OP_SRL:   y = a >> shamt;
      OP_PASSA: y = a;
    endcase
  end

endmodule

// File: rtl/vec_lane_alu.sv
// Element-serial vector ALU: latches an operand pair, computes one element per cycle,
// then presents the packed result and zero flag on a valid/ready handshake.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned ELEM_W = ELEM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned LANES = WIDTH / ELEM_W;
  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [2:0]       op_q;

  logic [ELEM_W-1:0] a_lane [LANES];
  logic [ELEM_W-1:0] b_lane [LANES];
  logic [ELEM_W-1:0] a_cur, b_cur, elem_res;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign a_lane[i] = a_q[i*ELEM_W +: ELEM_W];
    assign b_lane[i] = b_q[i*ELEM_W +: ELEM_W];
  end

  // Shift amount is B[2:0] of the whole operand, applied identically to every lane.
  assign a_cur = a_lane[idx_q];
  assign b_cur = is_shift(alu_op_t'(op_q)) ? b_lane[0] : b_lane[idx_q];

  vec_elem_op #(
    .ELEM_W (ELEM_W)
  ) u_elem_op (
    .op (op_q),
    .a  (a_cur),
    .b  (b_cur),
    .y  (elem_res)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_EXEC;
      S_EXEC:  if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && in_valid) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        res_q <= '0;
        idx_q <= '0;
      end
      if (state_q == S_EXEC) begin
        for (int i = 0; i < LANES; i++) begin
          if (idx_q == IDX_W'(i)) res_q[i*ELEM_W +: ELEM_W] <= elem_res;
        end
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign zero      = ~|res_q;

endmodule

// File: tb/tb_vec_lane_alu.sv
// Directed self-checking bench for vec_lane_alu (expectations follow VEC_ALU_SAT_EN).
module tb_vec_lane_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [23:0] a;
  logic [23:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] result;
  logic        zero;

  int n_checks = 0;
  int n_pass   = 0;

  vec_lane_alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one op, measure latency, optionally hold DONE under backpressure, then retire it.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [23:0] av,
                       input logic [23:0] bv, input logic [23:0] exp, input logic expz,
                       input int hold);
    int lat;
    @(negedge clk);
    for (int k = 0; k < 10 && !in_ready; k++) @(negedge clk);
    check_eq({tag, "_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    op        = o;
    a         = av;
    b         = bv;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a  = ~av;
    b  = ~bv;
    op = ~o;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq({tag, "_lat"}, lat, 3);
    check_eq({tag, "_res"}, result, exp);
    check_eq({tag, "_zero"}, zero, expz);
    check_eq({tag, "_busy"}, in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      a  = 24'h123456;
      b  = 24'h654321;
      op = 3'b000;
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_hold_res"}, result, exp);
      check_eq({tag, "_hold_valid"}, out_valid, 1);
      check_eq({tag, "_hold_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_ret_valid"}, out_valid, 0);
    check_eq({tag, "_ret_ready"}, in_ready, 1);
  endtask

  initial begin
    int n_acc;
    int n_res;
    int acc [2];
    int pulses;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 3'b000;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_result", result, 24'h000000);
    check_eq("rst_zero", zero, 1);
    rst = 1'b0;

`ifdef VEC_ALU_SAT_EN
    do_op("add", 3'b000, 24'h0102FF, 24'h010101, 24'h0203FF, 1'b0, 0);
    do_op("sub", 3'b001, 24'h000010, 24'h000020, 24'h000000, 1'b1, 0);
`else
    do_op("add", 3'b000, 24'h0102FF, 24'h010101, 24'h020300, 1'b0, 0);
    do_op("sub", 3'b001, 24'h000010, 24'h000020, 24'h0000F0, 1'b0, 0);
`endif
    do_op("sll",   3'b101, 24'h018040, 24'h000002, 24'h040000, 1'b0, 0);
    do_op("srl",   3'b110, 24'h80F001, 24'h000003, 24'h101E00, 1'b0, 0);
    do_op("or",    3'b011, 24'h00F00F, 24'h0F0F00, 24'h0FFF0F, 1'b0, 0);
    do_op("xorz",  3'b100, 24'h5A5A5A, 24'h5A5A5A, 24'h000000, 1'b1, 0);
    do_op("passa", 3'b111, 24'hABCDEF, 24'h111111, 24'hABCDEF, 1'b0, 0);
    do_op("bp",    3'b010, 24'hF0F0F0, 24'h3C3C3C, 24'h303030, 1'b0, 5);
    @(negedge clk);
    check_eq("bp_no_accept", in_ready, 1);

    // Reset mid-EXEC discards the partial result.
    in_valid  = 1'b1;
    op        = 3'b111;
    a         = 24'hABCDEF;
    b         = '0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_ready", in_ready, 1);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_result", result, 24'h000000);
    check_eq("mid_rst_zero", zero, 1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check_eq("mid_rst_pulses", pulses, 0);

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    in_valid  = 1'b1;
    op        = 3'b100;
    a         = 24'hFF00FF;
    b         = 24'h0F0F0F;
    out_ready = 1'b1;
    n_acc = 0;
    n_res = 0;
    acc[0] = 0;
    acc[1] = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        if (n_res == 0) check_eq("b2b_xor", result, 24'hF00FF0);
        else if (n_res == 1) check_eq("b2b_and", result, 24'h0F000F);
        n_res++;
      end
      if (in_valid && in_ready && n_acc < 2) begin
        acc[n_acc] = k;
        n_acc++;
      end
      @(negedge clk);
      if (n_acc == 1) op = 3'b010;
      if (n_acc == 2) in_valid = 1'b0;
    end
    check_eq("b2b_accepts", n_acc, 2);
    check_eq("b2b_spacing", acc[1] - acc[0], 5);
    check_eq("b2b_results", n_res, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
